// File: rtl/usb_rx_pkg.sv
// rtl/usb_rx_pkg.sv - shared states, SYNC/stuffing constants and PID nibbles for the USB receive sequencer
package usb_rx_pkg;

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        HUNT     = 3'd1,
        DATA     = 3'd2,
        EOP_WAIT = 3'd3,
        ERROR    = 3'd4
    } state_t;

    // Window value after 0,0,0,0,0,0,0,1 arrives LSB-first
    localparam logic [7:0] SYNC_PATTERN = 8'h80;

    // Consecutive ones after which the transmitter inserts a zero
    localparam logic [2:0] STUFF_LIMIT = 3'd6;

    // PID type nibbles (low nibble of the PID byte)
    localparam logic [3:0] PID_OUT   = 4'b0001;
    localparam logic [3:0] PID_IN    = 4'b1001;
    localparam logic [3:0] PID_SOF   = 4'b0101;
    localparam logic [3:0] PID_SETUP = 4'b1101;
    localparam logic [3:0] PID_DATA0 = 4'b0011;
    localparam logic [3:0] PID_DATA1 = 4'b1011;
    localparam logic [3:0] PID_ACK   = 4'b0010;
    localparam logic [3:0] PID_NAK   = 4'b1010;
    localparam logic [3:0] PID_STALL = 4'b1110;

    // A PID byte carries its type nibble and the complement of it in the high nibble
    function automatic logic pid_is_valid(input logic [7:0] pid);
        return pid[7:4] == ~pid[3:0];
    endfunction

endpackage

// File: rtl/usb_rx_bit_unstuffer.sv
// rtl/usb_rx_bit_unstuffer.sv - tracks run of ones and decides keep/discard/stuff error per received bit
module usb_rx_bit_unstuffer
    import usb_rx_pkg::*;
(
    input  logic clock,
    input  logic reset,
    input  logic init,
    input  logic bit_en,
    input  logic bit_in,
    output logic keep,
    output logic stuff_err
);

    logic [2:0] ones_cnt_q;
    logic [2:0] ones_cnt_d;
    logic       at_limit;

    assign at_limit = (ones_cnt_q == STUFF_LIMIT);

    // After six ones the next bit must be a stuffed zero: drop it, or flag a violation
    always_comb begin
        keep      = bit_en && !at_limit;
        stuff_err = bit_en && at_limit && bit_in;
    end

    // SYNC ends in a one, so the run starts at 1 when a packet begins
    always_comb begin
        ones_cnt_d = ones_cnt_q;
        if (init) begin
            ones_cnt_d = 3'd1;
        end else if (bit_en) begin
            if (at_limit || !bit_in) begin
                ones_cnt_d = 3'd0;
            end else begin
                ones_cnt_d = ones_cnt_q + 3'd1;
            end
        end
    end

    // Run-length register
    always_ff @(posedge clock) begin
        if (reset) begin
            ones_cnt_q <= 3'd0;
        end else begin
            ones_cnt_q <= ones_cnt_d;
        end
    end

endmodule

// File: rtl/usb_rx_sequencer.sv
// rtl/usb_rx_sequencer.sv - USB receive sequencer: SYNC hunt, unstuffing, byte assembly, EOP; USB_RX_PID_CHECK_EN adds PID check
module usb_rx_sequencer
    import usb_rx_pkg::*;
#(
    parameter int MAX_BYTES = 67
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       dec_bit,
    input  logic       dec_valid,
    input  logic       se0,
    output logic       rx_active,
    output logic [7:0] byte_out,
    output logic       byte_valid,
    output logic [6:0] byte_cnt,
    output logic       pkt_done,
    output logic       err_stuff,
    output logic       err_align,
    output logic       err_ovf,
    output logic       err_pid
);

    localparam logic [6:0] MAX_CNT = 7'(MAX_BYTES);

    state_t     state_q, state_d;
    logic [7:0] window_q, window_d;
    logic [7:0] shift_q, shift_d;
    logic [2:0] bit_cnt_q, bit_cnt_d;
    logic [6:0] byte_cnt_q, byte_cnt_d;
    logic [7:0] byte_out_q, byte_out_d;
    logic       byte_valid_q, byte_valid_d;
    logic       pkt_done_q, pkt_done_d;
    logic       err_stuff_q, err_stuff_d;
    logic       err_align_q, err_align_d;
    logic       err_ovf_q, err_ovf_d;

    logic       line_bit;
    logic       hunt_bit;
    logic       data_bit;
    logic [7:0] window_next;
    logic       sync_hit;
    logic       keep;
    logic       stuff_err;
    logic [7:0] assembled;
    logic       byte_done;
    logic       ovf;
    logic       eop_ok;
    logic       pid_bad;

    assign line_bit    = dec_valid && !se0;
    assign hunt_bit    = (state_q == HUNT) && line_bit;
    assign data_bit    = (state_q == DATA) && line_bit;
    assign window_next = {dec_bit, window_q[7:1]};
    assign sync_hit    = hunt_bit && (window_next == SYNC_PATTERN);
    assign assembled   = {dec_bit, shift_q[7:1]};
    assign byte_done   = keep && (bit_cnt_q == 3'd7);
    assign ovf         = byte_done && (byte_cnt_q == MAX_CNT);
    assign eop_ok      = (bit_cnt_q == 3'd0) && (byte_cnt_q != 7'd0);

    usb_rx_bit_unstuffer u_unstuffer (
        .clock     (clock),
        .reset     (reset),
        .init      (sync_hit),
        .bit_en    (data_bit),
        .bit_in    (dec_bit),
        .keep      (keep),
        .stuff_err (stuff_err)
    );

`ifdef USB_RX_PID_CHECK_EN
    logic err_pid_q, err_pid_d;

    assign pid_bad = byte_done && !ovf && (byte_cnt_q == 7'd0) && !pid_is_valid(assembled);
    assign err_pid = err_pid_q;
`else
    assign pid_bad = 1'b0;
    assign err_pid = 1'b0;
`endif

    // State and datapath registers
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q      <= IDLE;
            window_q     <= 8'h00;
            shift_q      <= 8'h00;
            bit_cnt_q    <= 3'd0;
            byte_cnt_q   <= 7'd0;
            byte_out_q   <= 8'h00;
            byte_valid_q <= 1'b0;
            pkt_done_q   <= 1'b0;
            err_stuff_q  <= 1'b0;
            err_align_q  <= 1'b0;
            err_ovf_q    <= 1'b0;
`ifdef USB_RX_PID_CHECK_EN
            err_pid_q    <= 1'b0;
`endif
        end else begin
            state_q      <= state_d;
            window_q     <= window_d;
            shift_q      <= shift_d;
            bit_cnt_q    <= bit_cnt_d;
            byte_cnt_q   <= byte_cnt_d;
            byte_out_q   <= byte_out_d;
            byte_valid_q <= byte_valid_d;
            pkt_done_q   <= pkt_done_d;
            err_stuff_q  <= err_stuff_d;
            err_align_q  <= err_align_d;
            err_ovf_q    <= err_ovf_d;
`ifdef USB_RX_PID_CHECK_EN
            err_pid_q    <= err_pid_d;
`endif
        end
    end

    // Next-state: se0 outranks data in DATA; error states wait for a fully idle line
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (line_bit) state_d = HUNT;
            end
            HUNT: begin
                if (!line_bit)     state_d = IDLE;
                else if (sync_hit) state_d = DATA;
            end
            DATA: begin
                if (se0)                          state_d = eop_ok ? EOP_WAIT : ERROR;
                else if (!dec_valid)              state_d = ERROR;
                else if (stuff_err || ovf || pid_bad) state_d = ERROR;
            end
            EOP_WAIT, ERROR: begin
                if (!se0 && !dec_valid) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // Datapath and strobes: window hunting, byte assembly, counters and one-cycle flags
    always_comb begin
        window_d     = window_q;
        shift_d      = shift_q;
        bit_cnt_d    = bit_cnt_q;
        byte_cnt_d   = byte_cnt_q;
        byte_out_d   = byte_out_q;
        byte_valid_d = 1'b0;
        pkt_done_d   = 1'b0;
        err_stuff_d  = 1'b0;
        err_align_d  = 1'b0;
        err_ovf_d    = 1'b0;
`ifdef USB_RX_PID_CHECK_EN
        err_pid_d    = 1'b0;
`endif
        case (state_q)
            IDLE: begin
                // Pre-fill with ones so a match needs all seven leading zeros
                if (line_bit) window_d = {dec_bit, 7'h7F};
            end
            HUNT: begin
                if (hunt_bit) window_d = window_next;
                if (sync_hit) begin
                    bit_cnt_d  = 3'd0;
                    byte_cnt_d = 7'd0;
                end
            end
            DATA: begin
                if (se0) begin
                    pkt_done_d  = eop_ok;
                    err_align_d = !eop_ok;
                end else if (!dec_valid) begin
                    err_align_d = 1'b1;
                end else begin
                    err_stuff_d = stuff_err;
                    if (keep) begin
                        shift_d   = assembled;
                        bit_cnt_d = bit_cnt_q + 3'd1;
                        if (byte_done) begin
                            if (ovf) begin
                                err_ovf_d = 1'b1;
                            end else begin
                                byte_out_d   = assembled;
                                byte_valid_d = 1'b1;
                                byte_cnt_d   = byte_cnt_q + 7'd1;
`ifdef USB_RX_PID_CHECK_EN
                                err_pid_d    = pid_bad;
`endif
                            end
                        end
                    end
                end
            end
            default: begin
            end
        endcase
    end

    // Output decode
    always_comb begin
        rx_active  = (state_q == DATA) || (state_q == EOP_WAIT);
        byte_out   = byte_out_q;
        byte_valid = byte_valid_q;
        byte_cnt   = byte_cnt_q;
        pkt_done   = pkt_done_q;
        err_stuff  = err_stuff_q;
        err_align  = err_align_q;
        err_ovf    = err_ovf_q;
    end

endmodule

// File: doc/usb_rx_sequencer.md
USB_RX_SEQUENCER -- requirements
Module: usb_rx_sequencer

Interface
REQ-001 SHALL have parameter MAX_BYTES, default 67, meaning the maximum bytes per packet (PID plus 64 data plus CRC16).
REQ-002 SHALL have port clock, input, 1 bit: the single clock; all logic is on its rising edge.
REQ-003 SHALL have port reset, input, 1 bit: synchronous, active-high reset.
REQ-004 SHALL have port dec_bit, input, 1 bit: the NRZI-decoded receive bit.
REQ-005 SHALL have port dec_valid, input, 1 bit: dec_bit is meaningful this cycle (decoder sending).
REQ-006 SHALL have port se0, input, 1 bit: the line is in SE0 (EOP signalling) this cycle.
REQ-007 SHALL have port rx_active, output, 1 bit: a packet is in progress after SYNC.
REQ-008 SHALL have port byte_out, output, 8 bits: the assembled byte, LSB received first.
REQ-009 SHALL have port byte_valid, output, 1 bit: one-cycle strobe qualifying byte_out.
REQ-010 SHALL have port byte_cnt, output, 7 bits: the number of bytes delivered in the current packet.
REQ-011 SHALL have port pkt_done, output, 1 bit: one-cycle strobe on a clean EOP.
REQ-012 SHALL have port err_stuff, err_align, err_ovf, err_pid, outputs, 1 bit each: one-cycle error strobes.

Function
REQ-013 SHALL implement the FSM states IDLE, HUNT, DATA, EOP_WAIT and ERROR.
REQ-014 IDLE SHALL go to HUNT on dec_valid=1 and se0=0, and SHALL shift that bit into an 8-bit window.
REQ-015 HUNT SHALL shift each valid bit into the window and, on the received sequence 0,0,0,0,0,0,0,1, SHALL go to DATA the next cycle with bit_cnt=0, byte_cnt=0 and ones_cnt=1.
REQ-016 In HUNT, dec_valid=0 or se0=1 SHALL cause a return to IDLE with no strobes.
REQ-017 In DATA, when ones_cnt==6, the next valid bit SHALL be discarded if it is 0 (ones_cnt becomes 0), and SHALL cause err_stuff and a transition to ERROR if it is 1.
REQ-018 In DATA, every other valid bit SHALL be shifted into byte_out LSB-first; ones_cnt SHALL increment on 1 and clear on 0, and bit_cnt SHALL increment.
REQ-019 When bit_cnt wraps from 7 to 0, byte_valid SHALL pulse in the same cycle the register updates (latency one clock from the eighth bit) and byte_cnt SHALL increment.
REQ-020 If byte_cnt==MAX_BYTES when a further byte completes, err_ovf SHALL pulse, the byte SHALL NOT be strobed, and the FSM SHALL go to ERROR.
REQ-021 In DATA, se0=1 SHALL take priority over dec_bit in the same cycle.
REQ-022 On se0 in DATA with bit_cnt==0 and byte_cnt>=1, pkt_done SHALL pulse and the FSM SHALL go to EOP_WAIT; otherwise err_align SHALL pulse and the FSM SHALL go to ERROR.
REQ-023 In DATA, dec_valid=0 with se0=0 SHALL cause err_align to pulse and the FSM to go to ERROR.
REQ-024 EOP_WAIT and ERROR SHALL return to IDLE on the first cycle with se0=0 and dec_valid=0.
REQ-025 rx_active SHALL be 1 exactly in the DATA and EOP_WAIT states.
REQ-026 byte_out SHALL hold its value between strobes.
REQ-027 byte_cnt SHALL hold its value until the next SYNC is detected.

Reset
REQ-028 reset=1 at a clock edge SHALL force IDLE, clear the window and all counters, and drive all outputs to 0 on that edge, including mid-packet.
REQ-029 After reset deasserts, the first SYNC SHALL be recognised with no extra latency.

Configuration
REQ-030 With USB_RX_PID_CHECK_EN defined, on the first byte of a packet, if byte_out[7:4] != ~byte_out[3:0], err_pid SHALL pulse with byte_valid and the FSM SHALL go to ERROR.
REQ-031 Without USB_RX_PID_CHECK_EN, err_pid SHALL be tied 0 and no PID check logic SHALL exist.

Structure
REQ-032 Package usb_rx_pkg SHALL hold the state enum, SYNC_PATTERN=8'h80 (LSB-first window value), STUFF_LIMIT=6, and the PID nibble constants.
REQ-033 Sub-module usb_rx_bit_unstuffer SHALL own ones_cnt and the discard/err_stuff decision; the FSM, byte assembly and counters SHALL live in the top level.

Verification
REQ-034 Bench SHALL drive SYNC, PID 8'hA5 (1,0,1,0,0,1,0,1), then se0 -> byte_valid with byte_out=8'hA5, byte_cnt=1, pkt_done one cycle after se0.
REQ-035 Bench SHALL drive SYNC, byte 8'hFF with a stuffed 0 after the sixth 1 -> byte_out=8'hFF and no err_stuff; a 1 in the stuffed position -> err_stuff, rx_active falls.
REQ-036 Bench SHALL drive SYNC, 11 bits, then se0 -> err_align, no pkt_done, IDLE once the line is idle.
REQ-037 Bench SHALL drive SYNC and MAX_BYTES+1 bytes -> 67 byte_valid strobes, then err_ovf.
REQ-038 Bench SHALL assert reset at the fourth bit of the second byte -> all outputs 0 next cycle; a following clean packet is received correctly.
REQ-039 With USB_RX_PID_CHECK_EN, bench SHALL drive PID 8'h12 -> err_pid with byte_valid; without the macro -> no error.
